// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with CPU I/O-mapped data, status and count/overflow registers
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rd,
    input  logic        io_rd,
    input  logic [15:0] io_addr,
    output logic [15:0] io_dout,
    output logic        io_hit
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          overflow;
    logic          rd_next, ovf_set, ovf_clr, push, pop, empty, full;
    logic          sel_data, sel_stat, sel_cnt;

    assign sel_data = (io_addr == 16'h4000);
    assign sel_stat = (io_addr == 16'h4002);
    assign sel_cnt  = (io_addr == 16'h4004);
    assign io_hit   = sel_data | sel_stat | sel_cnt;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign push    = (state == ACK);
    assign pop     = io_rd & sel_data & ~empty;
    assign ovf_clr = io_rd & sel_cnt;

    // Full decision uses the registered count, so a same-cycle pop only helps at the next IDLE.
    always_comb begin
        state_next = state;
        rd_next    = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            IDLE: begin
                if (uart_valid && !full) begin
                    state_next = ACK;
                    rd_next    = 1'b1;
                end
                ovf_set = uart_valid & full;
            end
            ACK:     state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            uart_rd  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            uart_rd  <= rd_next;
            overflow <= ovf_set | (overflow & ~ovf_clr);
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[tail] <= uart_rx_data;
    end

    always_comb begin
        io_dout = 16'h0000;
        if (sel_data && !empty) io_dout = {8'h00, mem[head]};
        else if (sel_stat)      io_dout = {15'b0, ~empty};
        else if (sel_cnt)       io_dout = {overflow, {(14-AW){1'b0}}, count};
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_valid = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rd;
    logic        io_rd = 1'b0;
    logic [15:0] io_addr = 16'h0000;
    logic [15:0] io_dout;
    logic        io_hit;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .reset(reset), .uart_valid(uart_valid), .uart_rx_data(uart_rx_data),
        .uart_rd(uart_rd), .io_rd(io_rd), .io_addr(io_addr), .io_dout(io_dout), .io_hit(io_hit)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] src_q[$];
    bit         rd_last = 1'b0;

    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    int         m_busy = 0;
    bit         m_live = 1'b0;

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // UART side pops its byte in the cycle after it sees its acknowledge.
    task automatic step(bit rd, logic [15:0] addr, bit rst);
        @(negedge clk);
        if (rd_last && src_q.size() > 0) void'(src_q.pop_front());
        rd_last      = (uart_rd === 1'b1);
        uart_valid   = (src_q.size() > 0);
        uart_rx_data = uart_valid ? src_q[0] : 8'h00;
        io_rd        = rd;
        io_addr      = addr;
        reset        = rst;
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, 16'h0000, 1'b0);
    endtask

    // Reference: a byte queue plus a cooldown of 2 cycles after every accepted byte.
    always @(posedge clk) begin
        int n;
        if (reset === 1'b1) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_busy = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            n = m_q.size();
            if (io_rd && io_addr == 16'h4000 && n > 0) void'(m_q.pop_front());
            if (m_busy == 2) m_q.push_back(uart_rx_data);
            m_ovf = (m_busy == 0 && uart_valid && n == DEPTH) ||
                    (m_ovf && !(io_rd && io_addr == 16'h4004));
            if (m_busy > 0) m_busy--;
            else if (uart_valid && n < DEPTH) m_busy = 2;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        bit          h;
        #2;
        if (m_live) begin
            h = (io_addr == 16'h4000) || (io_addr == 16'h4002) || (io_addr == 16'h4004);
            e = 16'h0000;
            if (io_addr == 16'h4000 && m_q.size() > 0) e = {8'h00, m_q[0]};
            else if (io_addr == 16'h4002)               e = (m_q.size() != 0) ? 16'd1 : 16'd0;
            else if (io_addr == 16'h4004)               e = (m_ovf ? 16'h8000 : 16'h0000) | 16'(m_q.size());
            check("model_io_dout", io_dout, e);
            check("model_io_hit", {15'b0, io_hit}, {15'b0, h});
            check("model_uart_rd", {15'b0, uart_rd}, (m_busy == 2) ? 16'd1 : 16'd0);
        end
    end

    initial begin
        int pulses;
        int got;
        int exp_next;
        int c;
        bit rd;
        logic [15:0] addr;

        step(1'b1, 16'h4000, 1'b1);
        step(1'b0, 16'h4002, 1'b1);
        step(1'b0, 16'h4002, 1'b0);
        check("reset_status", io_dout, 16'h0000);
        check("reset_uart_rd", {15'b0, uart_rd}, 16'h0000);
        step(1'b0, 16'h4004, 1'b0);
        check("reset_cnt_reg", io_dout, 16'h0000);

        // single byte
        src_q.push_back(8'h41);
        pulses = 0;
        repeat (6) begin
            idle(1);
            if (uart_rd === 1'b1) pulses++;
        end
        check("single_rd_pulses", 16'(pulses), 16'd1);
        step(1'b0, 16'h4002, 1'b0);
        check("single_status", io_dout, 16'h0001);
        step(1'b1, 16'h4000, 1'b0);
        check("single_data", io_dout, 16'h0041);
        step(1'b0, 16'h4002, 1'b0);
        check("single_empty", io_dout, 16'h0000);

        // decode holes
        step(1'b1, 16'h4001, 1'b0);
        check("dec_4001_hit", {15'b0, io_hit}, 16'h0000);
        check("dec_4001_dout", io_dout, 16'h0000);
        step(1'b1, 16'h4003, 1'b0);
        check("dec_4003_dout", io_dout, 16'h0000);

        // order across pointer wrap
        for (int i = 0; i < 20; i++) src_q.push_back(8'(i));
        exp_next = 0;
        for (int i = 0; i < 130; i++) begin
            rd = (i >= 30) && (i % 2 == 0);
            step(rd, 16'h4000, 1'b0);
            if (rd && m_q.size() > 0) begin
                check("order_data", io_dout, 16'(exp_next));
                exp_next++;
            end
        end
        check("order_count", 16'(exp_next), 16'd20);

        // full and overflow
        for (int i = 0; i < 17; i++) src_q.push_back(8'(8'hA0 + i));
        idle(60);
        step(1'b0, 16'h4004, 1'b0);
        check("full_cnt_reg", io_dout, 16'h8010);
        check("full_no_rd", {15'b0, uart_rd}, 16'h0000);
        step(1'b1, 16'h4000, 1'b0);
        check("full_head", io_dout, 16'h00A0);
        got = 0;
        repeat (2) begin
            idle(1);
            if (uart_rd === 1'b1) got = 1;
        end
        check("full_reaccept", 16'(got), 16'd1);
        idle(2);
        step(1'b1, 16'h4004, 1'b0);
        check("ovf_before_clr", io_dout, 16'h8010);
        step(1'b0, 16'h4004, 1'b0);
        check("ovf_after_clr", io_dout, 16'h0010);
        repeat (16) step(1'b1, 16'h4000, 1'b0);

        // empty read and read during ACK
        step(1'b1, 16'h4000, 1'b0);
        check("empty_read", io_dout, 16'h0000);
        src_q.push_back(8'h5A);
        idle(1);
        step(1'b1, 16'h4000, 1'b0);
        check("ack_rd", {15'b0, uart_rd}, 16'h0001);
        check("ack_read_zero", io_dout, 16'h0000);
        step(1'b0, 16'h4002, 1'b0);
        check("ack_status", io_dout, 16'h0001);
        step(1'b1, 16'h4000, 1'b0);
        check("ack_byte", io_dout, 16'h005A);

        // reset in HOLD with three bytes stored
        src_q.push_back(8'h01);
        src_q.push_back(8'h02);
        src_q.push_back(8'h03);
        pulses = 0;
        c = 0;
        while (pulses < 3 && c < 20) begin
            idle(1);
            if (uart_rd === 1'b1) pulses++;
            c++;
        end
        check("rst_pre_pulses", 16'(pulses), 16'd3);
        step(1'b1, 16'h4004, 1'b1);
        check("rst_hold_cnt", io_dout, 16'h0003);
        step(1'b0, 16'h4004, 1'b0);
        check("rst_post_cnt", io_dout, 16'h0000);
        check("rst_post_rd", {15'b0, uart_rd}, 16'h0000);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (src_q.size() < 3 && $urandom_range(0, 2) == 0) src_q.push_back(8'($urandom));
            rd = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1:    addr = 16'h4000;
                2:       addr = 16'h4002;
                3:       addr = 16'h4004;
                4:       addr = 16'h4001;
                default: addr = 16'($urandom);
            endcase
            step(rd, addr, $urandom_range(0, 399) == 0);
        end

        step(1'b0, 16'h0000, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning receive FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter AW, default 4, meaning log2(DEPTH) pointer width.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port uart_valid  input  1  UART receiver holds an unread byte.
REQ-006 SHALL have port uart_rx_data  input  8  UART received byte, stable while uart_valid=1.
REQ-007 SHALL have port uart_rd  output  1  registered one-cycle acknowledge that pops the UART receiver.
REQ-008 SHALL have port io_rd  input  1  CPU I/O read strobe, one cycle per access.
REQ-009 SHALL have port io_addr  input  16  CPU I/O address.
REQ-010 SHALL have port io_dout  output  16  combinational read data to CPU.
REQ-011 SHALL have port io_hit  output  1  combinational; 1 when io_addr is 16'h4000, 16'h4002 or 16'h4004.

Function
REQ-012 Ingest FSM SHALL have states IDLE, ACK, HOLD.
REQ-013 IDLE->ACK SHALL occur when uart_valid=1 and registered count<DEPTH; otherwise stay IDLE.
REQ-014 In ACK SHALL assert uart_rd=1 for exactly that cycle, write uart_rx_data at tail, advance tail (mod DEPTH), go to HOLD.
REQ-015 HOLD SHALL last one cycle, uart_rd=0, ignore uart_valid, then go to IDLE (guard cycle for valid to drop); max ingest rate one byte per 3 cycles.
REQ-016 Full decision SHALL use registered count; a pop in the same cycle does not allow acceptance until the next IDLE evaluation.
REQ-017 overflow flag SHALL set (sticky) in any IDLE cycle with uart_valid=1 and count==DEPTH; the byte is not acknowledged and stays in the UART.
REQ-018 Read 16'h4000: io_dout SHALL be {8'h00, head byte} if count>0, else 16'h0000.
REQ-019 io_rd=1 with io_addr=16'h4000 and count>0 SHALL advance head (mod DEPTH); with count==0 SHALL change nothing.
REQ-020 Read 16'h4002: io_dout SHALL be {15'b0, count!=0}; no side effect.
REQ-021 Read 16'h4004: io_dout SHALL be {overflow, 10'b0, count[AW:0]} zero-padded (count in low bits, AW+1 wide).
REQ-022 io_rd=1 at 16'h4004 SHALL clear overflow next cycle, unless a new overflow condition occurs that same cycle (set wins).
REQ-023 Any other io_addr SHALL give io_dout=16'h0000, io_hit=0, no side effect.
REQ-024 Simultaneous write (ACK) and pop SHALL update both pointers; count unchanged.
REQ-025 Pop and write with count==0 same cycle SHALL return 16'h0000 to CPU; byte stored, count becomes 1.
REQ-026 count SHALL be AW+1 bits, range 0..DEPTH, never wrap.
REQ-027 Storage read SHALL be asynchronous from head (distributed RAM); io_dout depends only on current state and io_addr.

Reset
REQ-028 reset=1 at a clock edge SHALL force FSM=IDLE, uart_rd=0, head=tail=0, count=0, overflow=0; FIFO contents undefined.
REQ-029 reset asserted during ACK or HOLD SHALL abort ingest; a byte acknowledged in ACK before reset is lost.
REQ-030 io_rd during reset SHALL have no effect; io_dout SHALL reflect post-reset state (4002 -> 16'h0000).

Verification
REQ-031 Single byte: uart_valid=1, data 8'h41 -> uart_rd pulse 1 cycle in ACK; 4002 reads 16'h0001; 4000 reads 16'h0041; then 4002 reads 16'h0000.
REQ-032 Order/wrap: push 20 bytes 8'h00..8'h13 while popping after 10 -> reads return 8'h00..8'h13 in order, zero-extended, across pointer wrap.
REQ-033 Full: 16 bytes pushed, uart_valid held -> no uart_rd, 4004 reads 16'h8010; one 4000 pop -> next accept within 2 cycles; 4004 read clears bit 15.
REQ-034 Empty read: 4000 with count 0 -> 16'h0000, head unchanged; read same cycle as ACK -> 16'h0000, then 4002 reads 16'h0001.
REQ-035 Decode: io_addr 16'h4001/16'h4003 with io_rd -> io_hit=0, io_dout=16'h0000, count unchanged.
REQ-036 Reset mid-ingest: reset in HOLD with 3 bytes stored -> next cycle count=0, uart_rd=0, 4004 reads 16'h0000.
